// File: rtl/bram36_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for bram36_fifo_ctrl.
//   WR_VALID/WR_READY/WR_DATA/WR_PAR : write side, producer -> FIFO
//   RD_VALID/RD_READY/RD_DATA/RD_PAR : first-word-fall-through read side, FIFO -> consumer
// master : the producer/consumer environment; slave : the FIFO controller.
interface bram36_fifo_ctrl_if;
    logic        WR_VALID;
    logic        WR_READY;
    logic [31:0] WR_DATA;
    logic [3:0]  WR_PAR;
    logic        RD_VALID;
    logic        RD_READY;
    logic [31:0] RD_DATA;
    logic [3:0]  RD_PAR;

    modport master (
        output WR_VALID, WR_DATA, WR_PAR, RD_READY,
        input  WR_READY, RD_VALID, RD_DATA, RD_PAR
    );

    modport slave (
        input  WR_VALID, WR_DATA, WR_PAR, RD_READY,
        output WR_READY, RD_VALID, RD_DATA, RD_PAR
    );
endinterface

// File: rtl/bram36_fifo_ctrl.sv
// Synchronous FIFO controller for one 512x36 true-dual-port block RAM.
// Writes go to RAM port A, reads come from RAM port B; a 2-entry output
// buffer hides the 1-cycle RAM read latency and presents a FWFT interface.
// Ports:
//   CLK, RST (sync, active-high), FLUSH (sync pointer/count clear)
//   bus        : write and read handshakes (slave modport)
//   LEVEL      : registered word count (RAM + in-flight + output buffer)
//   BRAM_*     : drive/consume RAM ports A (write) and B (read)
module bram36_fifo_ctrl #(
    parameter int unsigned AW   = 9,
    parameter int unsigned LVLW = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FLUSH,
    bram36_fifo_ctrl_if.slave    bus,
    output logic [LVLW-1:0]      LEVEL,
    output logic                 BRAM_ENA,
    output logic                 BRAM_WEA,
    output logic [AW-1:0]        BRAM_ADDRA,
    output logic [31:0]          BRAM_DIA,
    output logic [3:0]           BRAM_DIPA,
    output logic                 BRAM_ENB,
    output logic [AW-1:0]        BRAM_ADDRB,
    output logic                 BRAM_WEB,
    output logic                 BRAM_SSRA,
    output logic                 BRAM_SSRB,
    input  logic [31:0]          BRAM_DOB,
    input  logic [3:0]           BRAM_DOPB
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned WW    = 36;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] ram_cnt;
    logic          inflight;
    logic [1:0]    obuf_cnt;
    logic [WW-1:0] obuf_q [2];

    logic          clear;
    logic          wr_accept;
    logic          rd_issue;
    logic          pop;
    logic          rd_valid;
    logic [2:0]    obuf_credit;
    logic [1:0]    cnt_after_pop;
    logic [CW-1:0] ram_cnt_n;
    logic          inflight_n;
    logic [1:0]    obuf_cnt_n;
    logic [WW-1:0] obuf_n0;
    logic [WW-1:0] obuf_n1;

    // Handshakes and RAM strobes
    assign clear        = RST | FLUSH;
    assign bus.WR_READY = !clear && (ram_cnt != CW'(DEPTH));
    assign wr_accept    = bus.WR_VALID & bus.WR_READY;
    assign rd_valid     = (obuf_cnt != 2'd0);
    assign pop          = rd_valid & bus.RD_READY;

    // A same-cycle pop frees a buffer slot, so the read can issue against it;
    // this is what sustains 1 word/cycle out of the RAM with only 2 entries.
    assign obuf_credit  = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
    assign rd_issue     = !clear && (ram_cnt != CW'(0)) && (obuf_credit < 3'd2);

    assign BRAM_ENA   = wr_accept;
    assign BRAM_WEA   = wr_accept;
    assign BRAM_ADDRA = wptr;
    assign BRAM_DIA   = bus.WR_DATA;
    assign BRAM_DIPA  = bus.WR_PAR;
    assign BRAM_ENB   = rd_issue;
    assign BRAM_ADDRB = rptr;
    assign BRAM_WEB   = 1'b0;
    assign BRAM_SSRA  = 1'b0;
    assign BRAM_SSRB  = 1'b0;

    assign bus.RD_VALID = rd_valid;
    assign bus.RD_DATA  = obuf_q[0][WW-1:4];
    assign bus.RD_PAR   = obuf_q[0][3:0];

    // Next-state: counters and output-buffer shift/capture (entry 0 is the head)
    always_comb begin
        cnt_after_pop = obuf_cnt - 2'(pop);
        obuf_n0       = obuf_q[0];
        obuf_n1       = obuf_q[1];
        ram_cnt_n     = ram_cnt + CW'(wr_accept) - CW'(rd_issue);
        inflight_n    = rd_issue;
        obuf_cnt_n    = cnt_after_pop + 2'(inflight);

        if (pop) begin
            obuf_n0 = obuf_q[1];
        end
        if (inflight) begin
            if (cnt_after_pop == 2'd0) begin
                obuf_n0 = {BRAM_DOB, BRAM_DOPB};
            end else begin
                obuf_n1 = {BRAM_DOB, BRAM_DOPB};
            end
        end

        // Clear discards RAM contents, the in-flight read and the buffer
        if (clear) begin
            ram_cnt_n  = '0;
            inflight_n = 1'b0;
            obuf_cnt_n = '0;
        end
    end

    // Control state
    always_ff @(posedge CLK) begin
        if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= '0;
            LEVEL    <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_issue) begin
                rptr <= rptr + AW'(1);
            end
            ram_cnt  <= ram_cnt_n;
            inflight <= inflight_n;
            obuf_cnt <= obuf_cnt_n;
            LEVEL    <= LVLW'(ram_cnt_n) + LVLW'(inflight_n) + LVLW'(obuf_cnt_n);
        end
    end

    // Output buffer data; contents are don't-care while the count says empty
    always_ff @(posedge CLK) begin
        obuf_q[0] <= obuf_n0;
        obuf_q[1] <= obuf_n1;
    end
endmodule

// File: tb/tb_bram36_fifo_ctrl.sv
// Self-checking bench for bram36_fifo_ctrl with a behavioural 512x36 RAM.
module tb_bram36_fifo_ctrl;
    localparam int unsigned AW    = 9;
    localparam int unsigned LVLW  = 10;
    localparam int unsigned DEPTH = 512;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            RST;
    logic            FLUSH;
    logic [LVLW-1:0] LEVEL;
    logic            BRAM_ENA, BRAM_WEA, BRAM_ENB, BRAM_WEB, BRAM_SSRA, BRAM_SSRB;
    logic [AW-1:0]   BRAM_ADDRA, BRAM_ADDRB;
    logic [31:0]     BRAM_DIA, BRAM_DOB;
    logic [3:0]      BRAM_DIPA, BRAM_DOPB;

    bram36_fifo_ctrl_if bus();

    bram36_fifo_ctrl #(.AW(AW), .LVLW(LVLW)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .bus(bus), .LEVEL(LEVEL),
        .BRAM_ENA(BRAM_ENA), .BRAM_WEA(BRAM_WEA), .BRAM_ADDRA(BRAM_ADDRA),
        .BRAM_DIA(BRAM_DIA), .BRAM_DIPA(BRAM_DIPA), .BRAM_ENB(BRAM_ENB),
        .BRAM_ADDRB(BRAM_ADDRB), .BRAM_WEB(BRAM_WEB), .BRAM_SSRA(BRAM_SSRA),
        .BRAM_SSRB(BRAM_SSRB), .BRAM_DOB(BRAM_DOB), .BRAM_DOPB(BRAM_DOPB)
    );

    // Block RAM: write port A, registered read port B
    logic [35:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (BRAM_ENA && BRAM_WEA) ram[BRAM_ADDRA] <= {BRAM_DIA, BRAM_DIPA};
        if (BRAM_ENB) {BRAM_DOB, BRAM_DOPB} <= ram[BRAM_ADDRB];
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: the FIFO is just an ordered queue of accepted words
    logic [35:0] mq[$];

    // RAM-side invariants every cycle
    always @(negedge CLK) begin
        chk("bram_web", 64'(BRAM_WEB), 64'd0);
        chk("bram_ssra", 64'(BRAM_SSRA), 64'd0);
        chk("bram_ssrb", 64'(BRAM_SSRB), 64'd0);
        if (BRAM_ENA && BRAM_ENB)
            chk("port_collision", 64'(BRAM_ADDRA == BRAM_ADDRB), 64'd0);
    end

    // One clock: drive, observe handshake, update model, check LEVEL after edge
    task automatic cycle(input logic wv, input logic [31:0] wd, input logic [3:0] wp,
                         input logic rr, input logic fl,
                         output logic acc, output logic pd, output logic wr,
                         output logic [35:0] popped);
        logic [35:0] exp_w;
        bus.WR_VALID = wv;
        bus.WR_DATA  = wd;
        bus.WR_PAR   = wp;
        bus.RD_READY = rr;
        FLUSH        = fl;
        #1;
        wr     = bus.WR_READY;
        acc    = bus.WR_VALID & bus.WR_READY;
        pd     = bus.RD_VALID & bus.RD_READY;
        popped = {bus.RD_DATA, bus.RD_PAR};
        if (fl) begin
            chk("wr_ready_in_flush", 64'(wr), 64'd0);
        end else begin
            if (mq.size() < DEPTH) chk("wr_ready_open", 64'(wr), 64'd1);
            if (mq.size() == DEPTH + 2) chk("wr_ready_full", 64'(wr), 64'd0);
        end
        if (mq.size() == 0) chk("rd_valid_empty", 64'(bus.RD_VALID), 64'd0);
        if (fl) begin
            mq.delete();
        end else begin
            if (pd && mq.size() != 0) begin
                exp_w = mq.pop_front();
                chk("rd_word", 64'(popped), 64'(exp_w));
            end
            if (acc) mq.push_back({wd, wp});
        end
        @(posedge CLK);
        #1;
        chk("level", 64'(LEVEL), 64'(mq.size()));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        FLUSH = 1'b0;
        bus.WR_VALID = 1'b1;
        bus.WR_DATA  = 32'h5A5A5A5A;
        bus.WR_PAR   = 4'h5;
        bus.RD_READY = 1'b0;
        @(posedge CLK);
        #1;
        chk("wr_ready_in_rst", 64'(bus.WR_READY), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bus.WR_VALID = 1'b0;
        mq.delete();
        #1;
        chk("rst_level", 64'(LEVEL), 64'd0);
        chk("rst_rd_valid", 64'(bus.RD_VALID), 64'd0);
        chk("rst_wr_ready", 64'(bus.WR_READY), 64'd1);
    endtask

    typedef struct packed {
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  wp;
        logic        rr;
        logic        fl;
        logic        exp_wr_ready;
        logic [9:0]  exp_level;
        logic        exp_rd_valid;
        logic [31:0] exp_data;
        logic [3:0]  exp_par;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic acc, pd, wr;
        logic [35:0] popped;
        int sent, got, gap, pops, found;
        logic [31:0] dv;

        // Directed vectors from empty: latency, mixed push/pop, flush
        vt[0]  = '{1'b1, 32'h12345678, 4'hA, 1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 32'h0, 4'h0};
        vt[1]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 32'h0, 4'h0};
        vt[2]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 10'd1, 1'b1, 32'h12345678, 4'hA};
        vt[3]  = '{1'b1, 32'hDEADBEEF, 4'h5, 1'b1, 1'b0, 1'b1, 10'd1, 1'b0, 32'h0, 4'h0};
        vt[4]  = '{1'b1, 32'h0BADF00D, 4'h3, 1'b1, 1'b0, 1'b1, 10'd2, 1'b0, 32'h0, 4'h0};
        vt[5]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 10'd2, 1'b1, 32'hDEADBEEF, 4'h5};
        vt[6]  = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 10'd2, 1'b1, 32'hDEADBEEF, 4'h5};
        vt[7]  = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 10'd1, 1'b1, 32'h0BADF00D, 4'h3};
        vt[8]  = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 32'h0, 4'h0};
        vt[9]  = '{1'b1, 32'hCAFEF00D, 4'h1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 32'h0, 4'h0};
        vt[10] = '{1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 32'h0, 4'h0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].wv, vt[i].wd, vt[i].wp, vt[i].rr, vt[i].fl, acc, pd, wr, popped);
            chk($sformatf("vec%0d_wr_ready", i), 64'(wr), 64'(vt[i].exp_wr_ready));
            chk($sformatf("vec%0d_level", i), 64'(LEVEL), 64'(vt[i].exp_level));
            chk($sformatf("vec%0d_rd_valid", i), 64'(bus.RD_VALID), 64'(vt[i].exp_rd_valid));
            if (vt[i].exp_rd_valid)
                chk($sformatf("vec%0d_rd_word", i), 64'({bus.RD_DATA, bus.RD_PAR}),
                    64'({vt[i].exp_data, vt[i].exp_par}));
        end

        // Stream 1000 words with the consumer always ready: no gaps after the first
        do_reset();
        sent = 0; got = 0; gap = 0;
        for (int c = 0; c < 1100 && got < 1000; c++) begin
            cycle(sent < 1000, 32'(sent), 4'(sent), 1'b1, 1'b0, acc, pd, wr, popped);
            if (acc) sent++;
            if (pd) got++;
            if (got > 0 && got < 1000 && !bus.RD_VALID) gap++;
        end
        chk("stream_count", 64'(got), 64'd1000);
        chk("stream_gaps", 64'(gap), 64'd0);

        // Fill with consumer stalled, then collide write+pop at full, then drain
        do_reset();
        sent = 0;
        wr = 1'b1;
        for (int c = 0; c < 600 && wr; c++) begin
            cycle(1'b1, 32'h1000_0000 + 32'(sent), 4'($urandom), 1'b0, 1'b0, acc, pd, wr, popped);
            if (acc) sent++;
        end
        chk("fill_count", 64'(sent), 64'd514);
        chk("fill_level", 64'(LEVEL), 64'd514);
        for (int c = 0; c < 2; c++)
            cycle(1'b1, 32'hEEEE_0000, 4'hE, 1'b0, 1'b0, acc, pd, wr, popped);
        cycle(1'b1, 32'hEEEE_0001, 4'hE, 1'b1, 1'b0, acc, pd, wr, popped);
        chk("full_collide_accept", 64'(acc), 64'd0);
        chk("full_collide_pop", 64'(pd), 64'd1);
        pops = 1;
        found = 0;
        for (int c = 0; c < 4 && found == 0; c++) begin
            cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, acc, pd, wr, popped);
            if (wr) found = 1;
        end
        chk("reopen_after_pop", 64'(found), 64'd1);
        for (int c = 0; c < 700 && mq.size() != 0; c++) begin
            cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc, pd, wr, popped);
            if (pd) pops++;
        end
        chk("drain_count", 64'(pops), 64'd514);

        // Flush with a full output buffer and RAM words behind it
        do_reset();
        for (int c = 0; c < 4; c++)
            cycle(1'b1, 32'hF100_0000 + 32'(c), 4'(c), 1'b0, 1'b0, acc, pd, wr, popped);
        for (int c = 0; c < 3; c++)
            cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, acc, pd, wr, popped);
        cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc, pd, wr, popped);
        chk("flush_a_level", 64'(LEVEL), 64'd0);
        chk("flush_a_rd_valid", 64'(bus.RD_VALID), 64'd0);
        // Flush while a RAM read is in flight
        cycle(1'b1, 32'hF200_0000, 4'h2, 1'b0, 1'b0, acc, pd, wr, popped);
        cycle(1'b1, 32'hF200_0001, 4'h3, 1'b0, 1'b0, acc, pd, wr, popped);
        cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, acc, pd, wr, popped);
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, acc, pd, wr, popped);
            chk("flush_b_rd_valid", 64'(bus.RD_VALID), 64'd0);
        end
        cycle(1'b1, 32'h7777_1234, 4'h9, 1'b0, 1'b0, acc, pd, wr, popped);
        found = 0;
        for (int c = 0; c < 6 && found == 0; c++) begin
            cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, acc, pd, wr, popped);
            if (pd) begin
                found = 1;
                chk("flush_first_word", 64'(popped), 64'({32'h7777_1234, 4'h9}));
            end
        end
        chk("flush_first_word_seen", 64'(found), 64'd1);

        // Random traffic in phases that alternately fill and drain
        do_reset();
        dv = 32'h8000_0000;
        for (int c = 0; c < 10000; c++) begin
            int wpct, rpct;
            wpct = ((c / 1250) % 2 == 0) ? 90 : 35;
            rpct = ((c / 1250) % 2 == 0) ? 12 : 80;
            cycle(($urandom % 100) < 32'(wpct), dv, 4'($urandom), ($urandom % 100) < 32'(rpct),
                  ($urandom % 700) == 0, acc, pd, wr, popped);
            dv = dv + 32'd1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
